spi_ram_master: RTL and testbench

Host-side sequencer that drives the SPI slave + single-port RAM subsystem (SPI_TOP) over its four-wire link (SS_n, MOSI, MISO, shared clk). It accepts word-level read/write requests on a valid/ready port and expands each one into the required serial command frames: address frame then data frame. It optionally skips a redundant address frame, and returns read data on a one-cycle response strobe. It sits between the system bus glue and SPI_TOP, replacing the hand-driven frame sequences used in bring-up.

---
 rtl/spi_ram_master.sv | 182 ++++++++++++++++++
 tb/tb_spi_ram_master.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// Host-side sequencer for the SPI slave + RAM subsystem. Expands word-level read/write
// requests into serial address and data frames, with optional skipping of a repeated
// address frame, and returns read data on a one-cycle response strobe.
module spi_ram_master #(
  parameter int unsigned ADDR_CACHE = 1,
  parameter int unsigned GAP        = 1,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned CntW = 16;
  // Frame offsets (cnt holds the offset of the cycle currently on the wire)
  localparam logic [CntW-1:0] LastTx    = CntW'(11);
  localparam logic [CntW-1:0] LastGuard = CntW'(12);
  localparam logic [CntW-1:0] LastWait  = CntW'(11 + RD_LAT);
  localparam logic [CntW-1:0] LastCap   = CntW'(19 + RD_LAT);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StGap, StData, StRdWait, StCapture, StDone, StCool
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [12:0]     sr;
  logic [7:0]      rx;
  logic            wr_q;
  logic [7:0]      addr_q;
  logic [7:0]      wdata_q;
  logic            wr_c_vld;
  logic [7:0]      wr_c_addr;
  logic            rd_c_vld;
  logic [7:0]      rd_c_addr;

  logic            acc_skip;
  logic [12:0]     acc_frame;
  logic [12:0]     data_frame;

  // Full on-wire sequence F0..F12: idle bit, branch select, 10-bit word, guard bit
  function automatic logic [12:0] frame_bits(input logic [1:0] cmd, input logic [7:0] payload);
    return {1'b0, cmd[1], cmd, payload, 1'b0};
  endfunction

  // Skip decision and first frame for an incoming request, plus the pending data frame
  always_comb begin
    acc_skip = 1'b0;
    if (ADDR_CACHE != 0) begin
      acc_skip = req_wr ? (wr_c_vld && (wr_c_addr == req_addr))
                        : (rd_c_vld && (rd_c_addr == req_addr));
    end
    acc_frame  = acc_skip ? frame_bits({~req_wr, 1'b1}, req_wr ? req_wdata : 8'h00)
                          : frame_bits({~req_wr, 1'b0}, req_addr);
    data_frame = frame_bits({~wr_q, 1'b1}, wr_q ? wdata_q : 8'h00);
  end

  // Request sequencer; all link and handshake outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      sr        <= '0;
      rx        <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_c_vld  <= 1'b0;
      wr_c_addr <= '0;
      rd_c_vld  <= 1'b0;
      rd_c_addr <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            SS_n      <= 1'b0;
            MOSI      <= acc_frame[12];
            sr        <= {acc_frame[11:0], 1'b0};
            cnt       <= '0;
            state     <= acc_skip ? StData : StAddr;
          end
        end
        StAddr: begin
          cnt  <= cnt + 1'b1;
          MOSI <= sr[12];
          sr   <= {sr[11:0], 1'b0};
          if (cnt == LastGuard) begin
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
            cnt   <= '0;
            state <= StGap;
            if (wr_q) begin
              wr_c_vld  <= 1'b1;
              wr_c_addr <= addr_q;
            end else begin
              rd_c_vld  <= 1'b1;
              rd_c_addr <= addr_q;
            end
          end
        end
        StGap: begin
          if (cnt == GapLast) begin
            SS_n  <= 1'b0;
            MOSI  <= data_frame[12];
            sr    <= {data_frame[11:0], 1'b0};
            cnt   <= '0;
            state <= StData;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          cnt  <= cnt + 1'b1;
          MOSI <= sr[12];
          sr   <= {sr[11:0], 1'b0};
          if (!wr_q && (cnt == LastTx)) begin
            state <= StRdWait;
          end else if (wr_q && (cnt == LastGuard)) begin
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= StDone;
          end
        end
        StRdWait: begin
          cnt  <= cnt + 1'b1;
          MOSI <= 1'b0;
          if (cnt == LastWait) state <= StCapture;
        end
        StCapture: begin
          cnt <= cnt + 1'b1;
          rx  <= {rx[6:0], MISO};
          if (cnt == LastCap) begin
            rsp_rdata <= {rx[6:0], MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= StCool;
        end
        // Hold off the next request so consecutive frames stay GAP apart
        StCool: begin
          if (cnt == GapLast) begin
            req_ready <= 1'b1;
            state     <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI slave + RAM decodes the link and scores every
// frame against an expected-frame queue; request latency and read data come from a
// request-level model of the address caches and memory.
`timescale 1ns/1ps
module tb_spi_ram_master;

  localparam int ADDR_CACHE = 1;
  localparam int GAP        = 1;
  localparam int RD_LAT     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       MISO = 1'b0;
  logic       req_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_rdata;
  logic       nc_req_ready, nc_rsp_valid, nc_busy, nc_ss_n, nc_mosi;
  logic [7:0] nc_rsp_rdata;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] exp_mem [256];
  logic [7:0] s_ram [256];
  logic [9:0] exp_q [$];
  bit         m_wr_v, m_rd_v;
  logic [7:0] m_wr_a, m_rd_a;

  always #5 clk = ~clk;

  spi_ram_master #(.ADDR_CACHE(ADDR_CACHE), .GAP(GAP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  // Same requests, cache disabled: never skips an address frame
  spi_ram_master #(.ADDR_CACHE(0), .GAP(GAP), .RD_LAT(RD_LAT)) dut_nc (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(nc_req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(nc_rsp_valid),
    .rsp_rdata(nc_rsp_rdata), .busy(nc_busy), .SS_n(nc_ss_n), .MOSI(nc_mosi), .MISO(1'b0)
  );

  // ---------------- slave + RAM model (samples 1ns after each rising edge) ----------------
  int          s_off = -1;
  int          s_hi = 1000;
  logic [0:63] s_bits;
  logic [9:0]  s_word;
  logic [7:0]  s_wr_addr = 8'h00;
  logic [7:0]  s_rd_addr = 8'h00;
  logic [7:0]  s_byte;
  logic [9:0]  s_exp;
  logic [11:0] s_head;
  int          s_len;
  bit          s_tail_ok;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      s_off = -1;
      s_hi  = 1000;
      MISO  = 1'b0;
    end else if (!SS_n) begin
      if (s_off < 0) begin
        checks++;
        if (s_hi < GAP) begin
          errors++;
          $display("FAIL ss_gap: high for %0d cycles, need >= %0d", s_hi, GAP);
        end
        s_word = '0;
      end
      s_off++;
      if (s_off < 64) s_bits[s_off] = MOSI;
      if (s_off == 11) s_word = s_bits[2:11];
      if (s_word[9:8] == 2'b11 && s_off >= 12 + RD_LAT && s_off <= 19 + RD_LAT) begin
        s_byte = s_ram[s_rd_addr];
        MISO   = s_byte[7 - (s_off - 12 - RD_LAT)];
      end else begin
        MISO = 1'b0;
      end
      s_hi = 0;
    end else begin
      if (s_off >= 0) begin
        s_len = s_off + 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got word %h, none was due", s_word);
        end else begin
          s_exp     = exp_q.pop_front();
          s_head    = s_bits[0:11];
          s_tail_ok = 1'b1;
          for (int i = 12; i < s_len && i < 64; i++) if (s_bits[i] !== 1'b0) s_tail_ok = 1'b0;
          checks++;
          if (s_len != ((s_exp[9:8] == 2'b11) ? 20 + RD_LAT : 13)) begin
            errors++;
            $display("FAIL frame_len: word %h got %0d cycles", s_exp, s_len);
          end
          checks++;
          if (s_head !== {1'b0, s_exp[9], s_exp}) begin
            errors++;
            $display("FAIL frame_bits: got %b want %b", s_head, {1'b0, s_exp[9], s_exp});
          end
          checks++;
          if (!s_tail_ok) begin
            errors++;
            $display("FAIL frame_tail: word %h MOSI not 0 after F11", s_exp);
          end
        end
        case (s_word[9:8])
          2'b00: s_wr_addr = s_word[7:0];
          2'b01: s_ram[s_wr_addr] = s_word[7:0];
          2'b10: s_rd_addr = s_word[7:0];
          default: ;
        endcase
      end
      s_off = -1;
      MISO  = 1'b0;
      if (s_hi < 1000) s_hi++;
    end
  end

  // ---------------- request-level model ----------------
  task automatic model_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                           output bit skip);
    if (wr) begin
      skip = (ADDR_CACHE != 0) && m_wr_v && (m_wr_a == a);
      if (!skip) begin
        exp_q.push_back({2'b00, a});
        m_wr_v = 1'b1;
        m_wr_a = a;
      end
      exp_q.push_back({2'b01, d});
      exp_mem[a] = d;
    end else begin
      skip = (ADDR_CACHE != 0) && m_rd_v && (m_rd_a == a);
      if (!skip) begin
        exp_q.push_back({2'b10, a});
        m_rd_v = 1'b1;
        m_rd_a = a;
      end
      exp_q.push_back({2'b11, 8'h00});
    end
  endtask

  // Cycle (accept = 0) on which rsp_valid is expected
  function automatic int exp_rsp(input bit wr, input bit skip);
    return 1 + (skip ? 0 : 13 + GAP) + (wr ? 13 : 20 + RD_LAT);
  endfunction

  // ---------------- request driver: returns observations only ----------------
  task automatic run_req(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit hold,
                         input int abort_at, output int rsp_c, output int rdy_c,
                         output int nc_rsp_c, output logic [7:0] rdata, output int pulses,
                         output int busy_bad, output logic ss_after, output logic mosi_after);
    int n;
    int exp_busy;
    n = 0;
    rsp_c = -1; rdy_c = -1; nc_rsp_c = -1; rdata = 'x; pulses = 0; busy_bad = 0;
    ss_after = 'x; mosi_after = 'x;
    @(posedge clk); #1;
    while (!(req_ready && nc_req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready=%b nc_req_ready=%b, want 1", req_ready, nc_req_ready);
    end
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        pulses++;
        if (rsp_c < 0) begin
          rsp_c = c;
          rdata = rsp_rdata;
        end
      end
      if (nc_rsp_valid && nc_rsp_c < 0) nc_rsp_c = c;
      if (abort_at == 0 || c < abort_at) begin
        exp_busy = (rsp_c < 0) ? 1 : ((c == rsp_c) ? 1 : 0);
        if (int'(busy) != exp_busy) busy_bad++;
        if (c == 1 && (req_ready || !nc_busy)) busy_bad++;
        if (nc_rsp_valid && nc_rsp_rdata !== 8'h00) busy_bad++;
        if (req_ready && rdy_c < 0) rdy_c = c;
      end
      if (abort_at == c) begin
        #1 rst = 1'b1;
        #1;
        ss_after   = SS_n;
        mosi_after = MOSI;
      end
      if (hold && rsp_c < 0) begin
        req_valid = 1'b1;
        req_wr    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (abort_at > 0 && c >= abort_at + 2) break;
      if (abort_at == 0 && rdy_c >= 0 && nc_req_ready) break;
    end
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n got %b want 1", SS_n); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", MOSI); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_wr_v = 1'b0; m_rd_v = 1'b0;
  endtask

  task automatic test_write_read();
    bit sk; int rc, yc, nrc, pl, bb; logic [7:0] rd; logic s1, m1;
    model_req(1'b1, 8'h04, 8'h0F, sk);
    run_req(1'b1, 8'h04, 8'h0F, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 28) begin errors++; $display("FAIL wr_rsp_cycle got %0d want 28", rc); end
    checks++; if (yc !== 30) begin errors++; $display("FAIL wr_ready_cycle got %0d want 30", yc); end
    checks++; if (pl !== 1 || bb !== 0) begin errors++; $display("FAIL wr_pulse_busy got %0d/%0d want 1/0", pl, bb); end
    checks++; if (s_ram[4] !== 8'h0F) begin errors++; $display("FAIL wr_ram got %h want 0f", s_ram[4]); end
    model_req(1'b0, 8'h04, 8'h00, sk);
    run_req(1'b0, 8'h04, 8'h00, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 37) begin errors++; $display("FAIL rd_rsp_cycle got %0d want 37", rc); end
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL rd_data got %h want 0f", rd); end
    checks++; if (pl !== 1 || bb !== 0) begin errors++; $display("FAIL rd_pulse_busy got %0d/%0d want 1/0", pl, bb); end
  endtask

  task automatic test_addr_cache();
    bit sk; int rc, yc, nrc, pl, bb; logic [7:0] rd; logic s1, m1;
    model_req(1'b1, 8'h04, 8'hA5, sk);
    run_req(1'b1, 8'h04, 8'hA5, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 14) begin errors++; $display("FAIL skip_rsp_cycle got %0d want 14", rc); end
    checks++; if (yc !== 16) begin errors++; $display("FAIL skip_ready_cycle got %0d want 16", yc); end
    checks++; if (nrc !== 28) begin errors++; $display("FAIL nocache_rsp_cycle got %0d want 28", nrc); end
    checks++; if (s_ram[4] !== 8'hA5) begin errors++; $display("FAIL skip_ram got %h want a5", s_ram[4]); end
  endtask

  task automatic test_separate_cache();
    bit sk; int rc, yc, nrc, pl, bb; logic [7:0] rd; logic s1, m1;
    model_req(1'b1, 8'h05, 8'h5A, sk);
    run_req(1'b1, 8'h05, 8'h5A, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 28) begin errors++; $display("FAIL wr05_rsp_cycle got %0d want 28", rc); end
    model_req(1'b0, 8'h05, 8'h00, sk);
    run_req(1'b0, 8'h05, 8'h00, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 37) begin errors++; $display("FAIL rd05_rsp_cycle got %0d want 37", rc); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL rd05_data got %h want 5a", rd); end
    model_req(1'b0, 8'h06, 8'h00, sk);
    run_req(1'b0, 8'h06, 8'h00, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 37) begin errors++; $display("FAIL rd06_rsp_cycle got %0d want 37", rc); end
    checks++; if (rd !== exp_mem[6]) begin errors++; $display("FAIL rd06_data got %h want %h", rd, exp_mem[6]); end
    model_req(1'b0, 8'h06, 8'h00, sk);
    run_req(1'b0, 8'h06, 8'h00, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 23) begin errors++; $display("FAIL rd06_skip_rsp_cycle got %0d want 23", rc); end
  endtask

  task automatic test_busy_ignore();
    bit sk; int rc, yc, nrc, pl, bb; logic [7:0] rd; logic s1, m1;
    model_req(1'b1, 8'h07, 8'h3C, sk);
    run_req(1'b1, 8'h07, 8'h3C, 1'b1, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== exp_rsp(1'b1, sk)) begin errors++; $display("FAIL hold_rsp_cycle got %0d want %0d", rc, exp_rsp(1'b1, sk)); end
    checks++; if (yc !== rc + GAP + 1) begin errors++; $display("FAIL hold_ready_cycle got %0d want %0d", yc, rc + GAP + 1); end
    checks++; if (pl !== 1 || bb !== 0) begin errors++; $display("FAIL hold_pulse_busy got %0d/%0d want 1/0", pl, bb); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL hold_frames_left got %0d want 0", exp_q.size()); end
    checks++; if (s_ram[7] !== 8'h3C) begin errors++; $display("FAIL hold_ram got %h want 3c", s_ram[7]); end
  endtask

  task automatic test_reset_mid_frame();
    bit sk; int rc, yc, nrc, pl, bb; logic [7:0] rd; logic s1, m1;
    model_req(1'b1, 8'h07, 8'h3C, sk);
    run_req(1'b1, 8'h07, 8'h3C, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    // Cache hit: data frame F0 on cycle 1, so F7 on cycle 8
    model_req(1'b1, 8'h07, 8'h3C, sk);
    run_req(1'b1, 8'h07, 8'h3C, 1'b0, 8, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL abort_ss_n got %b want 1", s1); end
    checks++; if (m1 !== 1'b0) begin errors++; $display("FAIL abort_mosi got %b want 0", m1); end
    checks++; if (pl !== 0) begin errors++; $display("FAIL abort_rsp_pulses got %0d want 0", pl); end
    exp_q.delete();
    m_wr_v = 1'b0; m_rd_v = 1'b0;
    rst = 1'b0;
    model_req(1'b1, 8'h07, 8'h3C, sk);
    run_req(1'b1, 8'h07, 8'h3C, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rc !== 28) begin errors++; $display("FAIL post_rst_rsp_cycle got %0d want 28", rc); end
    model_req(1'b0, 8'h07, 8'h00, sk);
    run_req(1'b0, 8'h07, 8'h00, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
    checks++; if (rd !== 8'h3C || rc !== 37) begin errors++; $display("FAIL post_rst_read got %h@%0d want 3c@37", rd, rc); end
  endtask

  task automatic test_random();
    bit sk, wr; int rc, yc, nrc, pl, bb, er; logic [7:0] rd, a, d, erd; logic s1, m1;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'h10 + 8'($urandom_range(0, 3));
      d  = 8'($urandom);
      model_req(wr, a, d, sk);
      er  = exp_rsp(wr, sk);
      erd = exp_mem[a];
      run_req(wr, a, d, 1'b0, 0, rc, yc, nrc, rd, pl, bb, s1, m1);
      checks++; if (rc !== er) begin errors++; $display("FAIL rnd%0d_rsp_cycle got %0d want %0d", i, rc, er); end
      checks++; if (yc !== er + GAP + 1) begin errors++; $display("FAIL rnd%0d_ready_cycle got %0d want %0d", i, yc, er + GAP + 1); end
      checks++; if (nrc !== exp_rsp(wr, 1'b0)) begin errors++; $display("FAIL rnd%0d_nc_rsp got %0d want %0d", i, nrc, exp_rsp(wr, 1'b0)); end
      checks++; if (pl !== 1 || bb !== 0) begin errors++; $display("FAIL rnd%0d_pulse_busy got %0d/%0d want 1/0", i, pl, bb); end
      if (!wr) begin
        checks++; if (rd !== erd) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, rd, erd); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'h00;
      s_ram[i]   = 8'h00;
    end
    m_wr_v = 1'b0; m_rd_v = 1'b0; m_wr_a = 8'h00; m_rd_a = 8'h00;
    test_reset();
    test_write_read();
    test_addr_cache();
    test_separate_cache();
    test_busy_ignore();
    test_reset_mid_frame();
    test_random();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL frames_outstanding got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
